// File: rtl/ft8_tx_sequencer.sv
// ---------------------------------------------------------------------------
// ft8_tx_sequencer
//
// Transmit-side controller around the FT8 modulator datapath. It collects a
// host text message, streams it to the modulator as a fixed-length burst
// (padding with spaces), captures the resulting tone indices, then replays
// them to the tone generator after a qualifying slot boundary, holding each
// tone for one symbol period.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   msg_char[7:0]         host ASCII character
//   msg_char_valid        host character strobe
//   msg_end               marks msg_char as the last character
//   msg_char_ready        high when a host character can be accepted
//   slot_tick             one-cycle pulse at each slot boundary
//   tx_enable             permits transmission at slot_tick
//   abort                 synchronous abort, highest priority
//   mod_ascii[7:0]        character to the modulator
//   mod_data_valid        character strobe to the modulator
//   mod_symbol[2:0]       modulator tone index
//   mod_symbol_valid      modulator tone strobe
//   mod_message_complete  modulator end-of-message pulse
//   tone[2:0]             current transmit tone (holds when tone_valid=0)
//   tone_valid            high for the whole transmit window
//   tone_strobe           pulse on the first cycle of each symbol
//   busy                  high in any state other than IDLE
//   error                 sticky fault flag, cleared by the next accepted char
//   state_dbg[2:0]        current FSM state encoding
//
// Handshake: a host character is consumed on any rising clock edge where
// msg_char_valid && msg_char_ready; msg_end is meaningful only on that edge.
// The modulator side has no backpressure: mod_data_valid and
// mod_symbol_valid are single-cycle strobes consumed unconditionally.
// ---------------------------------------------------------------------------
module ft8_tx_sequencer #(
   parameter int MSG_MAX        = 13,
   parameter int NUM_SYMBOLS    = 79,
   parameter int SYM_PERIOD_CYC = 1920,
   parameter int TIMEOUT_CYC    = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] msg_char,
   input  logic       msg_char_valid,
   input  logic       msg_end,
   output logic       msg_char_ready,
   input  logic       slot_tick,
   input  logic       tx_enable,
   input  logic       abort,
   output logic [7:0] mod_ascii,
   output logic       mod_data_valid,
   input  logic [2:0] mod_symbol,
   input  logic       mod_symbol_valid,
   input  logic       mod_message_complete,
   output logic [2:0] tone,
   output logic       tone_valid,
   output logic       tone_strobe,
   output logic       busy,
   output logic       error,
   output logic [2:0] state_dbg
);

   localparam int CHAR_W = $clog2(MSG_MAX);
   localparam int SYM_W  = $clog2(NUM_SYMBOLS);
   localparam int PER_W  = $clog2(SYM_PERIOD_CYC);
   localparam int TMO_W  = $clog2(TIMEOUT_CYC);

   localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(MSG_MAX - 1);
   localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(NUM_SYMBOLS - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SYM_PERIOD_CYC - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_FEED    = 3'd2,
      S_COLLECT = 3'd3,
      S_ARMED   = 3'd4,
      S_TX      = 3'd5
   } state_t;

   state_t state;
   state_t next_state;

   logic [7:0]        char_buf [MSG_MAX];
   logic [2:0]        sym_buf  [NUM_SYMBOLS];
   logic [CHAR_W-1:0] char_cnt;
   logic [CHAR_W-1:0] feed_idx;
   logic [SYM_W-1:0]  sym_cnt;
   logic [SYM_W-1:0]  tx_idx;
   logic [PER_W-1:0]  per_cnt;
   logic [TMO_W-1:0]  tmo_cnt;

   logic accept_char;
   logic collect_fault;
   logic tx_start;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      next_state    = state;
      accept_char   = 1'b0;
      collect_fault = 1'b0;
      tx_start      = 1'b0;
      case (state)
         S_IDLE: begin
            if (msg_char_valid) begin
               accept_char = 1'b1;
               next_state  = msg_end ? S_FEED : S_LOAD;
            end
         end
         S_LOAD: begin
            if (msg_char_valid) begin
               accept_char = 1'b1;
               // This write fills the last slot when char_cnt is MSG_MAX-1.
               if (msg_end || char_cnt == CHAR_LAST) next_state = S_FEED;
            end
         end
         S_FEED: begin
            if (feed_idx == CHAR_LAST) next_state = S_COLLECT;
         end
         S_COLLECT: begin
            // Completion is only legitimate together with the final symbol;
            // a completion on its own means the modulator came up short.
            if (mod_symbol_valid && sym_cnt == SYM_LAST) begin
               next_state = S_ARMED;
            end else if (mod_message_complete) begin
               collect_fault = 1'b1;
               next_state    = S_IDLE;
            end else if (!mod_symbol_valid && tmo_cnt == TMO_LAST) begin
               collect_fault = 1'b1;
               next_state    = S_IDLE;
            end
         end
         S_ARMED: begin
            if (slot_tick && tx_enable) begin
               tx_start   = 1'b1;
               next_state = S_TX;
            end
         end
         S_TX: begin
            if (per_cnt == PER_LAST && tx_idx == SYM_LAST) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
      if (abort) begin
         next_state    = S_IDLE;
         accept_char   = 1'b0;
         collect_fault = 1'b0;
         tx_start      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // ---------------------------------------------------------------------
   // Buffers and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MSG_MAX; i++)     char_buf[i] <= '0;
         for (int i = 0; i < NUM_SYMBOLS; i++) sym_buf[i]  <= '0;
         char_cnt <= '0;
         feed_idx <= '0;
         sym_cnt  <= '0;
         tx_idx   <= '0;
         per_cnt  <= '0;
         tmo_cnt  <= '0;
         tone     <= '0;
      end else if (abort) begin
         char_cnt <= '0;
         feed_idx <= '0;
         sym_cnt  <= '0;
         tx_idx   <= '0;
         per_cnt  <= '0;
         tmo_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept_char) begin
                  char_buf[0] <= msg_char;
                  char_cnt    <= CHAR_W'(1);
               end
            end
            S_LOAD: begin
               if (accept_char) begin
                  char_buf[char_cnt] <= msg_char;
                  char_cnt           <= char_cnt + 1'b1;
               end
            end
            S_FEED: begin
               if (feed_idx == CHAR_LAST) begin
                  feed_idx <= '0;
                  sym_cnt  <= '0;
                  tmo_cnt  <= '0;
               end else begin
                  feed_idx <= feed_idx + 1'b1;
               end
            end
            S_COLLECT: begin
               if (mod_symbol_valid) begin
                  sym_buf[sym_cnt] <= mod_symbol;
                  tmo_cnt          <= '0;
                  // Compare against the last index rather than NUM_SYMBOLS
                  // so the counter never needs to represent NUM_SYMBOLS.
                  sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
               if (collect_fault) begin
                  sym_cnt <= '0;
                  tmo_cnt <= '0;
               end
            end
            S_ARMED: begin
               if (tx_start) begin
                  tone    <= sym_buf[0];
                  tx_idx  <= '0;
                  per_cnt <= '0;
               end
            end
            S_TX: begin
               if (per_cnt == PER_LAST) begin
                  per_cnt <= '0;
                  if (tx_idx == SYM_LAST) begin
                     tx_idx <= '0;
                  end else begin
                     tx_idx <= tx_idx + 1'b1;
                     tone   <= sym_buf[tx_idx + 1'b1];
                  end
               end else begin
                  per_cnt <= per_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             error <= 1'b0;
      else if (accept_char)   error <= 1'b0;
      else if (collect_fault) error <= 1'b1;
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   // Gated by rst_n so every output reads 0 while reset is held.
   assign msg_char_ready = rst_n && (state == S_IDLE || state == S_LOAD);
   assign mod_data_valid = (state == S_FEED);
   assign mod_ascii      = (state != S_FEED)     ? 8'h00 :
                           (feed_idx < char_cnt) ? char_buf[feed_idx] : 8'h20;
   assign tone_valid     = (state == S_TX);
   assign tone_strobe    = (state == S_TX) && (per_cnt == '0);
   assign busy           = (state != S_IDLE);
   assign state_dbg      = state;

endmodule
